// File: rtl/uart_rx_intr.sv
// 8N1 UART receiver with an interrupt-style handshake: a committed byte raises irr
// until the CPU acknowledges; overrun and frame_err are sticky until acknowledged.
module uart_rx_intr #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd,
   input  logic        intr_ack,
   output logic        irr,
   output logic [31:0] r_data,
   output logic        overrun,
   output logic        frame_err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t          state, state_nxt;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;

   logic            cnt_clr, cnt_run, do_shift, do_commit, do_ferr;

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_run   = 1'b0;
      do_shift  = 1'b0;
      do_commit = 1'b0;
      do_ferr   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               cnt_clr   = 1'b1;
            end
         end
         START: begin
            cnt_run = 1'b1;
            if (cnt == HALF_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            cnt_run = 1'b1;
            if (cnt == FULL_LAST) begin
               cnt_clr  = 1'b1;
               do_shift = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            cnt_run = 1'b1;
            if (cnt == FULL_LAST) begin
               cnt_clr = 1'b1;
               if (rx_s) begin
                  do_commit = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  do_ferr   = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            // Counter is held at zero here so a long break can never wrap it.
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shift   <= 8'd0;
      end else begin
         if (cnt_clr)      cnt <= '0;
         else if (cnt_run) cnt <= cnt + 1'b1;

         if (state == START) bit_idx <= 3'd0;
         else if (do_shift)  bit_idx <= bit_idx + 3'd1;

         if (do_shift) shift <= {rx_s, shift[7:1]};
      end
   end

   // A commit outranks a simultaneous acknowledge; the ack still clears the sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irr       <= 1'b0;
         r_data    <= 32'd0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else if (do_commit) begin
         irr       <= 1'b1;
         r_data    <= {24'd0, shift};
         overrun   <= intr_ack ? 1'b0 : (overrun | irr);
         frame_err <= intr_ack ? 1'b0 : frame_err;
      end else begin
         if (intr_ack) begin
            irr     <= 1'b0;
            overrun <= 1'b0;
         end
         if (do_ferr)       frame_err <= 1'b1;
         else if (intr_ack) frame_err <= 1'b0;
      end
   end

endmodule
